// File: rtl/nash_pkg.sv
// Shared types for the Nash cipher stream controller: FSM states, key bundle, default widths.
// No logic, so no latency.
// No flow control of its own.
package nash_pkg;

    localparam int NASH_DATA_W    = 8;
    localparam int NASH_MEM_DEPTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        CORE_RST,
        CFG,
        SETTLE,
        READY,
        SHIFT,
        WAIT_OUT,
        OUT
    } state_t;

    typedef struct packed {
        logic [NASH_MEM_DEPTH-1:0] red_perm;
        logic [NASH_MEM_DEPTH-1:0] red_inv;
        logic [NASH_MEM_DEPTH-1:0] blue_perm;
        logic [NASH_MEM_DEPTH-1:0] blue_inv;
    } key_t;

endpackage

// File: rtl/nash_bit_serdes.sv
// Bit serialiser/deserialiser: PISO feeding the core MSB-first, and a SIPO with bit counter collecting core output.
// PISO emits its first bit in the cycle after tx_load; SIPO reports rx_full in the cycle after the DATA_W-th bit.
// No handshake: bits arriving while rx_full is set are dropped until rx_clr.
module nash_bit_serdes #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_load,
    input  logic [DATA_W-1:0] tx_dat,
    input  logic              tx_shift,
    output logic              tx_bit,
    output logic              tx_last,
    input  logic              rx_clr,
    input  logic              rx_vld,
    input  logic              rx_bit,
    output logic [DATA_W-1:0] rx_dat,
    output logic              rx_full
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] tx_sreg;
    logic [CNT_W-1:0]  tx_cnt;
    logic [CNT_W-1:0]  rx_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_sreg <= '0;
            tx_cnt  <= '0;
        end else if (tx_load) begin
            tx_sreg <= tx_dat;
            tx_cnt  <= '0;
        end else if (tx_shift) begin
            tx_sreg <= {tx_sreg[DATA_W-2:0], 1'b0};
            tx_cnt  <= tx_cnt + CNT_W'(1);
        end
    end

    assign tx_bit  = tx_sreg[DATA_W-1];
    assign tx_last = (tx_cnt == CNT_W'(DATA_W - 1));

    // Counting bits rather than cycles makes the collector independent of core latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_dat <= '0;
            rx_cnt <= '0;
        end else if (rx_clr) begin
            rx_cnt <= '0;
        end else if (rx_vld && !rx_full) begin
            rx_dat <= {rx_dat[DATA_W-2:0], rx_bit};
            rx_cnt <= rx_cnt + CNT_W'(1);
        end
    end

    assign rx_full = (rx_cnt == CNT_W'(DATA_W));

endmodule

// File: rtl/nash_stream_ctrl.sv
// Byte-stream sequencer for the bit-serial Nash core: keying, per-byte serialise/deserialise, re-key after s_last.
// Latency per byte: 1 accept + DATA_W shift + core latency + 1 collect, then OUT until m_ready.
// s_ready only in READY (and not while key_load); m_data held in OUT until m_ready. Watchdog: NASH_CTRL_TIMEOUT_EN.
module nash_stream_ctrl
    import nash_pkg::*;
#(
    parameter int DATA_W         = NASH_DATA_W,
    parameter int MEM_DEPTH      = NASH_MEM_DEPTH,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MEM_DEPTH-1:0] key_red_perm,
    input  logic [MEM_DEPTH-1:0] key_red_inv,
    input  logic [MEM_DEPTH-1:0] key_blue_perm,
    input  logic [MEM_DEPTH-1:0] key_blue_inv,
    input  logic                 key_load,
    output logic                 key_ready,
    input  logic [DATA_W-1:0]    s_data,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic [DATA_W-1:0]    m_data,
    output logic                 m_valid,
    output logic                 m_last,
    input  logic                 m_ready,
    output logic                 core_rst_n,
    output logic                 core_cfg_valid,
    input  logic                 core_cfg_ready,
    output logic [MEM_DEPTH-1:0] core_red_perm,
    output logic [MEM_DEPTH-1:0] core_red_inv,
    output logic [MEM_DEPTH-1:0] core_blue_perm,
    output logic [MEM_DEPTH-1:0] core_blue_inv,
    output logic                 core_bit_in,
    output logic                 core_valid_in,
    input  logic                 core_bit_out,
    input  logic                 core_valid_out,
    output logic                 err
);

    localparam int SC_W = $clog2(SETTLE_CYCLES + 1);

    state_t            state_q, state_d;
    key_t              key_q;
    logic              last_q;
    logic [SC_W-1:0]   settle_cnt;
    logic              key_accept, byte_accept, timeout;
    logic              tx_shift, tx_bit, tx_last, rx_clr, rx_full;

    assign key_accept  = key_load && (state_q == IDLE || state_q == READY);
    assign byte_accept = s_valid && s_ready;
    assign key_ready   = key_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            key_q      <= '0;
            last_q     <= 1'b0;
            settle_cnt <= '0;
        end else begin
            state_q    <= state_d;
            settle_cnt <= (state_q == SETTLE) ? settle_cnt + SC_W'(1) : '0;
            if (key_accept)
                key_q <= {key_red_perm, key_red_inv, key_blue_perm, key_blue_inv};
            if (byte_accept)
                last_q <= s_last;
        end
    end

    always_comb begin
        state_d        = state_q;
        s_ready        = 1'b0;
        core_rst_n     = 1'b1;
        core_cfg_valid = 1'b0;
        core_valid_in  = 1'b0;
        m_valid        = 1'b0;
        tx_shift       = 1'b0;
        rx_clr         = 1'b0;
        case (state_q)
            IDLE: begin
                core_rst_n = 1'b0;
                rx_clr     = 1'b1;
                if (key_accept) state_d = CORE_RST;
            end
            CORE_RST: begin
                core_rst_n = 1'b0;
                rx_clr     = 1'b1;
                state_d    = CFG;
            end
            CFG: begin
                core_cfg_valid = 1'b1;
                rx_clr         = 1'b1;
                if (core_cfg_ready) state_d = SETTLE;
            end
            SETTLE: begin
                rx_clr = 1'b1;
                if (settle_cnt == SC_W'(SETTLE_CYCLES - 1)) state_d = READY;
            end
            READY: begin
                // A simultaneous key_load wins; the byte stays upstream until re-keyed.
                s_ready = !key_load;
                if (key_accept) begin
                    state_d = CORE_RST;
                end else if (s_valid) begin
                    rx_clr  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                core_valid_in = 1'b1;
                tx_shift      = 1'b1;
                if (tx_last) state_d = WAIT_OUT;
            end
            WAIT_OUT: begin
                if (rx_full) begin
                    state_d = OUT;
                end else if (timeout) begin
                    rx_clr  = 1'b1;
                    state_d = CORE_RST;
                end
            end
            OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    rx_clr  = 1'b1;
                    state_d = last_q ? CORE_RST : READY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef NASH_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
    logic            err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            to_cnt <= (state_q == WAIT_OUT) ? to_cnt + TO_W'(1) : '0;
            if (key_accept)
                err_q <= 1'b0;
            else if (timeout)
                err_q <= 1'b1;
        end
    end

    assign timeout = (state_q == WAIT_OUT) && !rx_full && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign err     = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // rx_clr holds the collector empty in all pre-READY states, so stray core bits are harmless there.
    nash_bit_serdes #(.DATA_W(DATA_W)) u_serdes (
        .clk      (clk),
        .rst      (rst),
        .tx_load  (byte_accept),
        .tx_dat   (s_data),
        .tx_shift (tx_shift),
        .tx_bit   (tx_bit),
        .tx_last  (tx_last),
        .rx_clr   (rx_clr),
        .rx_vld   (core_valid_out),
        .rx_bit   (core_bit_out),
        .rx_dat   (m_data),
        .rx_full  (rx_full)
    );

    assign core_bit_in    = core_valid_in & tx_bit;
    assign m_last         = m_valid & last_q;
    assign core_red_perm  = key_q.red_perm;
    assign core_red_inv   = key_q.red_inv;
    assign core_blue_perm = key_q.blue_perm;
    assign core_blue_inv  = key_q.blue_inv;

endmodule

// File: tb/tb_nash_stream_ctrl.sv
// Directed bench for nash_stream_ctrl with an inverting, 1-cycle-latency core model.
// Vector table for byte transforms plus hand sequences for keying, collisions, reset and watchdog.
module tb_nash_stream_ctrl;

    localparam int DW = 8;
    localparam int MD = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [MD-1:0] key_red_perm = '0, key_red_inv = '0, key_blue_perm = '0, key_blue_inv = '0;
    logic          key_load = 1'b0;
    logic          key_ready;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0, s_last = 1'b0;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid, m_last;
    logic          m_ready = 1'b0;
    logic          core_rst_n, core_cfg_valid;
    logic          core_cfg_ready = 1'b0;
    logic [MD-1:0] core_red_perm, core_red_inv, core_blue_perm, core_blue_inv;
    logic          core_bit_in, core_valid_in;
    logic          core_bit_out = 1'b0, core_valid_out = 1'b0;
    logic          err;

    logic          core_mute = 1'b0;
    logic          inject = 1'b0;
    logic [DW-1:0] tx_shadow = '0;
    int            vin_cnt = 0;
    int            mvalid_cnt = 0;
    int            checks = 0;
    int            errors = 0;

    typedef struct {
        logic [DW-1:0] din;
        logic          last;
        logic [DW-1:0] dout;
        int            stall;
    } vec_t;

    always #5 clk = ~clk;

    nash_stream_ctrl dut (
        .clk(clk), .rst(rst),
        .key_red_perm(key_red_perm), .key_red_inv(key_red_inv),
        .key_blue_perm(key_blue_perm), .key_blue_inv(key_blue_inv),
        .key_load(key_load), .key_ready(key_ready),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .core_rst_n(core_rst_n), .core_cfg_valid(core_cfg_valid), .core_cfg_ready(core_cfg_ready),
        .core_red_perm(core_red_perm), .core_red_inv(core_red_inv),
        .core_blue_perm(core_blue_perm), .core_blue_inv(core_blue_inv),
        .core_bit_in(core_bit_in), .core_valid_in(core_valid_in),
        .core_bit_out(core_bit_out), .core_valid_out(core_valid_out),
        .err(err)
    );

    // Core model: inverted bit, one cycle later; cfg_ready answers after one cycle of cfg_valid.
    always @(posedge clk) begin
        core_valid_out <= (core_valid_in & ~core_mute) | inject;
        core_bit_out   <= ~core_bit_in;
        core_cfg_ready <= core_cfg_valid & ~core_cfg_ready;
        if (core_valid_in) begin
            tx_shadow <= {tx_shadow[DW-2:0], core_bit_in};
            vin_cnt   <= vin_cnt + 1;
        end
        if (m_valid) mvalid_cnt <= mvalid_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!s_ready && n < 100) begin
            step();
            n++;
        end
        chk({nm, "_s_ready_wait"}, 32'(s_ready), 32'd1);
    endtask

    task automatic wait_mvalid(input string nm);
        int n = 0;
        while (!m_valid && n < 100) begin
            step();
            n++;
        end
        chk({nm, "_m_valid_wait"}, 32'(m_valid), 32'd1);
    endtask

    task automatic load_key(input logic [31:0] k);
        {key_red_perm, key_red_inv, key_blue_perm, key_blue_inv} = k;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
    endtask

    task automatic push_byte(input logic [DW-1:0] d, input logic l);
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic take_byte();
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   n;
        int   v0;
        int   mv0;
        logic [DW-1:0] held;

        vecs[0] = '{8'hB3, 1'b1, 8'h4C, 0};
        vecs[1] = '{8'h00, 1'b0, 8'hFF, 0};
        vecs[2] = '{8'hFF, 1'b0, 8'h00, 5};
        vecs[3] = '{8'hA5, 1'b1, 8'h5A, 0};
        vecs[4] = '{8'h3C, 1'b0, 8'hC3, 0};
        vecs[5] = '{8'h81, 1'b1, 8'h7E, 0};

        // Reset state
        repeat (3) step();
        chk("reset_ctrl_outs",
            32'({key_ready, s_ready, m_valid, m_last, core_rst_n, core_cfg_valid, core_valid_in, core_bit_in, err}),
            32'd0);
        chk("reset_m_data", 32'(m_data), 32'd0);
        chk("reset_keys", {core_red_perm, core_red_inv, core_blue_perm, core_blue_inv}, 32'd0);
        rst = 1'b0;
        step();

        // Key handshake
        {key_red_perm, key_red_inv, key_blue_perm, key_blue_inv} = 32'h271C1EE2;
        key_load = 1'b1;
        #1;
        chk("key_ready_idle", 32'(key_ready), 32'd1);
        step();
        key_load = 1'b0;
        chk("core_rst_pulse", 32'(core_rst_n), 32'd0);
        step();
        chk("cfg_entry", 32'({core_rst_n, core_cfg_valid}), 32'b11);
        chk("core_key_words", {core_red_perm, core_red_inv, core_blue_perm, core_blue_inv}, 32'h271C1EE2);
        n = 0;
        while (core_cfg_valid && n < 20) begin
            step();
            n++;
        end
        chk("cfg_valid_cycles", 32'(n), 32'd2);
        n = 0;
        while (!s_ready && n < 20) begin
            step();
            n++;
        end
        chk("settle_cycles", 32'(n), 32'd2);

        // Byte vectors
        for (int i = 0; i < 6; i++) begin
            wait_ready($sformatf("vec%0d", i));
            push_byte(vecs[i].din, vecs[i].last);
            wait_mvalid($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_core_bits", i), 32'(tx_shadow), 32'(vecs[i].din));
            if (vecs[i].stall > 0) begin
                held   = m_data;
                v0     = vin_cnt;
                inject = 1'b1;
                for (int s = 0; s < vecs[i].stall; s++) begin
                    step();
                    chk($sformatf("vec%0d_stall%0d_hold", i, s), 32'({m_valid, m_data}), 32'({1'b1, held}));
                end
                inject = 1'b0;
                chk($sformatf("vec%0d_no_vin_in_stall", i), 32'(vin_cnt), 32'(v0));
            end
            chk($sformatf("vec%0d_m_data", i), 32'(m_data), 32'(vecs[i].dout));
            chk($sformatf("vec%0d_m_last", i), 32'(m_last), 32'(vecs[i].last));
            take_byte();
            if (vecs[i].last)
                chk($sformatf("vec%0d_rekey", i), 32'(core_rst_n), 32'd0);
        end

        // key_load while shifting is ignored
        wait_ready("shift_key");
        push_byte(8'h5A, 1'b0);
        chk("shift_active", 32'(core_valid_in), 32'd1);
        {key_red_perm, key_red_inv, key_blue_perm, key_blue_inv} = 32'h99887766;
        key_load = 1'b1;
        #1;
        chk("shift_key_ready", 32'(key_ready), 32'd0);
        step();
        key_load = 1'b0;
        chk("shift_keys_kept", {core_red_perm, core_red_inv, core_blue_perm, core_blue_inv}, 32'h271C1EE2);
        wait_mvalid("shift_key");
        chk("shift_key_m_data", 32'(m_data), 32'hA5);
        take_byte();

        // key_load and s_valid together in READY: key wins, byte waits
        wait_ready("collide");
        s_data  = 8'h12;
        s_last  = 1'b1;
        s_valid = 1'b1;
        {key_red_perm, key_red_inv, key_blue_perm, key_blue_inv} = 32'h11223344;
        key_load = 1'b1;
        #1;
        chk("collide_s_ready", 32'(s_ready), 32'd0);
        chk("collide_key_ready", 32'(key_ready), 32'd1);
        step();
        key_load = 1'b0;
        chk("collide_core_rst", 32'(core_rst_n), 32'd0);
        chk("collide_new_keys", {core_red_perm, core_red_inv, core_blue_perm, core_blue_inv}, 32'h11223344);
        wait_ready("collide_held");
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
        wait_mvalid("collide");
        chk("collide_m_data", 32'({m_last, m_data}), 32'({1'b1, 8'hED}));
        take_byte();

        // Reset in the middle of a shift
        wait_ready("midrst");
        push_byte(8'h77, 1'b0);
        repeat (4) step();
        chk("midrst_shifting", 32'(core_valid_in), 32'd1);
        rst = 1'b1;
        step();
        chk("midrst_outs", 32'({m_valid, core_rst_n, core_valid_in, s_ready}), 32'd0);
        chk("midrst_keys", {core_red_perm, core_red_inv, core_blue_perm, core_blue_inv}, 32'd0);
        rst = 1'b0;
        mv0 = mvalid_cnt;
        repeat (20) step();
        chk("midrst_no_output", 32'(mvalid_cnt), 32'(mv0));

        load_key(32'h271C1EE2);
        wait_ready("post_rst");

`ifdef NASH_CTRL_TIMEOUT_EN
        core_mute = 1'b1;
        push_byte(8'h0F, 1'b0);
        n = 0;
        while (core_valid_in && n < 20) begin
            step();
            n++;
        end
        n = 0;
        while (!err && n < 200) begin
            step();
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'd64);
        chk("timeout_rekey", 32'(core_rst_n), 32'd0);
        core_mute = 1'b0;
        wait_ready("after_timeout");
        push_byte(8'h0F, 1'b1);
        wait_mvalid("after_timeout");
        chk("after_timeout_m_data", 32'(m_data), 32'hF0);
        take_byte();
        wait_ready("err_sticky");
        chk("err_sticky", 32'(err), 32'd1);
        load_key(32'h271C1EE2);
        chk("err_cleared", 32'(err), 32'd0);
`else
        push_byte(8'hC0, 1'b0);
        wait_mvalid("no_watchdog");
        chk("no_watchdog_m_data", 32'({m_data, err}), 32'({8'h3F, 1'b0}));
        take_byte();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
